// File: rtl/serdes_pkg.sv
// Shared types and sizing helpers for the serial receive alignment path.
package serdes_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

  function automatic int bc_width(input int lock_count);
    return (lock_count < 1) ? 1 : $clog2(lock_count + 1);
  endfunction

  function automatic int miss_width(input int loss_count);
    return (loss_count < 1) ? 1 : $clog2(loss_count + 1);
  endfunction

endpackage

// File: rtl/sp_shift_counter.sv
// Serial shift register plus free-running bit counter; realign restarts the
// word framing so the word completing now becomes the reference boundary.
module sp_shift_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             data_in,
  input  logic             realign,
  output logic [WIDTH-1:0] word_next,
  output logic             boundary
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

  assign word_next = {shift_q, data_in};
  assign boundary  = (bit_cnt_q == LAST);

  always_comb begin
    shift_d = word_next[WIDTH-2:0];
    if (realign || boundary) begin
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/serial_parallel_align.sv
// Serial-to-parallel receiver with bit-level comma alignment and lock tracking.
//   state  | meaning
//   HUNT   | search every bit offset for COMMA
//   COUNT  | framed on a comma, counting consecutive aligned commas
//   LOCKED | delivering words; misaligned commas counted toward unlock
module serial_parallel_align
  import serdes_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 2
) (
  input  logic                            clk_8f,
  input  logic                            reset,
  input  logic                            data_in,
  output logic [WIDTH-1:0]                data_out,
  output logic                            valid_out,
  output logic                            word_tick,
  output logic                            active,
  output logic [$clog2(LOCK_COUNT+1)-1:0] bc_counter
);

  localparam int BCW = bc_width(LOCK_COUNT);
  localparam int MW  = miss_width(LOSS_COUNT);
  localparam logic [BCW-1:0] BC_PRELOCK = BCW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0]  MISS_LAST  = MW'(LOSS_COUNT - 1);

  align_state_e     state_q, state_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             tick_q, tick_d;
  logic             active_q, active_d;

  logic [WIDTH-1:0] word_next;
  logic             boundary;
  logic             realign;
  logic             is_comma;

  sp_shift_counter #(.WIDTH(WIDTH)) u_shift (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .data_in   (data_in),
    .realign   (realign),
    .word_next (word_next),
    .boundary  (boundary)
  );

  assign is_comma = (word_next == COMMA);

  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    miss_d     = miss_q;
    misalign_d = misalign_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    tick_d     = 1'b0;
    active_d   = active_q;
    realign    = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (is_comma) begin
          realign    = 1'b1;
          bc_d       = BCW'(1);
          miss_d     = '0;
          misalign_d = 1'b0;
          if (LOCK_COUNT == 1) begin
            state_d  = LOCKED;
            active_d = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end

      COUNT: begin
        if (boundary) begin
          data_d = word_next;
          tick_d = 1'b1;
          if (is_comma) begin
            bc_d = bc_q + BCW'(1);
            if (bc_q == BC_PRELOCK) begin
              state_d  = LOCKED;
              active_d = 1'b1;
            end
          end else begin
            bc_d    = '0;
            state_d = HUNT;
          end
        end
      end

      LOCKED: begin
        if (boundary) begin
          data_d     = word_next;
          tick_d     = 1'b1;
          valid_d    = !is_comma;
          misalign_d = 1'b0;
          // An aligned comma outranks any misaligned one seen in the same word.
          if (is_comma) begin
            miss_d = '0;
          end else if (misalign_q) begin
            if (miss_q == MISS_LAST) begin
              state_d  = HUNT;
              active_d = 1'b0;
              valid_d  = 1'b0;
              bc_d     = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end else if (is_comma) begin
          misalign_d = 1'b1;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      bc_q       <= '0;
      miss_q     <= '0;
      misalign_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      tick_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      miss_q     <= miss_d;
      misalign_q <= misalign_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      tick_q     <= tick_d;
      active_q   <= active_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign word_tick  = tick_q;
  assign active     = active_q;
  assign bc_counter = bc_q;

endmodule

// File: tb/tb_serial_parallel_align.sv
// Bench for serial_parallel_align: default 8-bit instance plus a 10-bit sweep instance.
module tb_serial_parallel_align;
  import serdes_pkg::*;

  logic clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  logic       reset, data_in;
  logic [7:0] data_out;
  logic       valid_out, word_tick, active;
  logic [2:0] bc_counter;

  logic       reset2, data_in2;
  logic [9:0] data_out2;
  logic       valid_out2, word_tick2, active2;
  logic [0:0] bc_counter2;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  serial_parallel_align dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .word_tick  (word_tick),
    .active     (active),
    .bc_counter (bc_counter)
  );

  serial_parallel_align #(
    .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(1), .LOSS_COUNT(1)
  ) dut2 (
    .clk_8f     (clk_8f),
    .reset      (reset2),
    .data_in    (data_in2),
    .data_out   (data_out2),
    .valid_out  (valid_out2),
    .word_tick  (word_tick2),
    .active     (active2),
    .bc_counter (bc_counter2)
  );

  // Scoreboard: every valid word from the 8-bit instance must match the queue head.
  always @(posedge clk_8f) begin
    #1;
    if (valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: data_out=%h, no word expected", data_out);
      end else begin
        exp_word = exp_q.pop_front();
        if (data_out !== exp_word) begin
          errors++;
          $display("FAIL valid_word: data_out=%h expected %h", data_out, exp_word);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, output int ticks, output int tick_at);
    ticks = 0;
    tick_at = -1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (word_tick === 1'b1) begin
        ticks++;
        tick_at = 7 - i;
      end
    end
  endtask

  task automatic send_bit2(input logic b);
    data_in2 = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic send_word2(input logic [9:0] w, output int ticks, output int tick_at);
    ticks = 0;
    tick_at = -1;
    for (int i = 9; i >= 0; i--) begin
      send_bit2(w[i]);
      if (word_tick2 === 1'b1) begin
        ticks++;
        tick_at = 9 - i;
      end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    int t, ta;
    for (int i = 0; i < 20; i++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_8f);
      #1;
      if (data_out !== 8'h00 || valid_out !== 1'b0 || word_tick !== 1'b0 ||
          active !== 1'b0 || bc_counter !== 3'd0 || dut.state_q !== HUNT) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_hold: %0d cycles with nonzero outputs or state, expected 0", bad);
    end
    reset = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (bc_counter !== 3'd0 || active !== 1'b0) begin
      errors++;
      $display("FAIL junk_bits: bc=%0d active=%b expected 0 0", bc_counter, active);
    end
    for (int k = 1; k <= 4; k++) begin
      send_word(8'hBC, t, ta);
      checks++;
      if (bc_counter !== 3'(k)) begin
        errors++;
        $display("FAIL lock_bc_%0d: bc=%0d expected %0d", k, bc_counter, k);
      end
      checks++;
      if (active !== (k == 4)) begin
        errors++;
        $display("FAIL lock_active_%0d: active=%b expected %b", k, active, (k == 4));
      end
    end
  endtask

  task automatic test_locked_data();
    int t, ta;
    exp_q.push_back(8'h5A);
    send_word(8'h5A, t, ta);
    checks++;
    if (t != 1 || ta != 7) begin
      errors++;
      $display("FAIL tick_5a: ticks=%0d at bit %0d expected 1 at 7", t, ta);
    end
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL valid_5a: valid_out=%b expected 1", valid_out);
    end
    send_word(8'hBC, t, ta);
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'hBC || t != 1 || ta != 7) begin
      errors++;
      $display("FAIL comma_word: valid=%b data=%h ticks=%0d at %0d expected 0 bc 1 at 7",
               valid_out, data_out, t, ta);
    end
    exp_q.push_back(8'hC3);
    send_word(8'hC3, t, ta);
    checks++;
    if (valid_out !== 1'b1 || t != 1 || ta != 7) begin
      errors++;
      $display("FAIL valid_c3: valid=%b ticks=%0d at %0d expected 1 1 at 7", valid_out, t, ta);
    end
    send_bit(1'b1);
    checks++;
    if (valid_out !== 1'b0 || word_tick !== 1'b0 || data_out !== 8'hC3) begin
      errors++;
      $display("FAIL pulse_width: valid=%b tick=%b data=%h expected 0 0 c3",
               valid_out, word_tick, data_out);
    end
    for (int i = 6; i >= 0; i--) send_bit(((8'hBC >> i) & 8'h01) != 0);
  endtask

  task automatic test_count_interrupt();
    int t, ta;
    reset = 1'b0;
    @(posedge clk_8f);
    #1;
    reset = 1'b1;
    send_word(8'hBC, t, ta);
    send_word(8'hBC, t, ta);
    checks++;
    if (bc_counter !== 3'd2 || active !== 1'b0) begin
      errors++;
      $display("FAIL count_two: bc=%0d active=%b expected 2 0", bc_counter, active);
    end
    send_word(8'h00, t, ta);
    checks++;
    if (bc_counter !== 3'd0 || dut.state_q !== HUNT || t != 1) begin
      errors++;
      $display("FAIL count_break: bc=%0d state=%0d ticks=%0d expected 0 HUNT 1",
               bc_counter, dut.state_q, t);
    end
    for (int k = 0; k < 4; k++) send_word(8'hBC, t, ta);
    checks++;
    if (bc_counter !== 3'd4 || active !== 1'b1) begin
      errors++;
      $display("FAIL relock: bc=%0d active=%b expected 4 1", bc_counter, active);
    end
  endtask

  task automatic test_misalign();
    logic [7:0] cw = 8'hBC;
    logic       b;
    int fall_at = -1;
    int rise_at = -1;
    logic [2:0] bc_fall = 3'd7;
    logic [7:0] held = 8'h00;
    // one slip bit then six commas; two pre-unlock boundaries carry 8'h5E
    exp_q.push_back(8'h5E);
    exp_q.push_back(8'h5E);
    for (int j = 1; j <= 49; j++) begin
      b = (j == 1) ? 1'b0 : cw[7 - ((j - 2) % 8)];
      send_bit(b);
      if (active !== 1'b1 && fall_at < 0) fall_at = j;
      if (active === 1'b1 && fall_at >= 0 && rise_at < 0) rise_at = j;
      if (j == 24) bc_fall = bc_counter;
      if (j == 30) held = data_out;
    end
    checks++;
    if (fall_at != 24) begin
      errors++;
      $display("FAIL unlock_edge: active fell at %0d expected 24", fall_at);
    end
    checks++;
    if (bc_fall !== 3'd0) begin
      errors++;
      $display("FAIL unlock_bc: bc=%0d expected 0", bc_fall);
    end
    checks++;
    if (held !== 8'h5E) begin
      errors++;
      $display("FAIL hunt_holds_data: data_out=%h expected 5e", held);
    end
    checks++;
    if (rise_at != 49 || bc_counter !== 3'd4) begin
      errors++;
      $display("FAIL relock_edge: rose at %0d bc=%0d expected 49 4", rise_at, bc_counter);
    end
  endtask

  task automatic test_reset_midword();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (active !== 1'b1 || data_out !== 8'hBC) begin
      errors++;
      $display("FAIL pre_reset: active=%b data=%h expected 1 bc", active, data_out);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || word_tick !== 1'b0 ||
        active !== 1'b0 || bc_counter !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: data=%h valid=%b tick=%b active=%b bc=%0d expected all 0",
               data_out, valid_out, word_tick, active, bc_counter);
    end
  endtask

  task automatic test_param_sweep();
    logic [9:0] cw = 10'h17C;
    logic       b;
    int t, ta;
    int fall_at = -1;
    @(posedge clk_8f);
    #1;
    reset2 = 1'b1;
    send_word2(10'h17C, t, ta);
    checks++;
    if (active2 !== 1'b1 || bc_counter2 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_lock: active=%b bc=%0d expected 1 1", active2, bc_counter2);
    end
    send_word2(10'h3FF, t, ta);
    checks++;
    if (valid_out2 !== 1'b1 || data_out2 !== 10'h3FF || t != 1 || ta != 9) begin
      errors++;
      $display("FAIL sweep_word: valid=%b data=%h ticks=%0d at %0d expected 1 3ff 1 at 9",
               valid_out2, data_out2, t, ta);
    end
    send_word2(10'h17C, t, ta);
    checks++;
    if (valid_out2 !== 1'b0 || t != 1 || ta != 9) begin
      errors++;
      $display("FAIL sweep_period: valid=%b ticks=%0d at %0d expected 0 1 at 9", valid_out2, t, ta);
    end
    for (int j = 1; j <= 21; j++) begin
      b = (j == 1) ? 1'b0 : cw[9 - ((j - 2) % 10)];
      send_bit2(b);
      if (active2 !== 1'b1 && fall_at < 0) fall_at = j;
    end
    checks++;
    if (fall_at != 20) begin
      errors++;
      $display("FAIL sweep_unlock: active fell at %0d expected 20", fall_at);
    end
  endtask

  initial begin
    reset    = 1'b0;
    data_in  = 1'b0;
    reset2   = 1'b0;
    data_in2 = 1'b0;
    @(posedge clk_8f);
    #1;
    test_reset();
    test_locked_data();
    test_count_interrupt();
    test_misalign();
    test_reset_midword();
    test_param_sweep();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d words left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
